// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory access stage.
// Byte-lane steering, valid/ready bus handshake, load extension, timeout.
module load_store_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_rvalid_i
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_WAIT_R, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic          r_valid, w_valid;
  logic          r_we, w_we;
  logic [31:0]   r_addr, w_addr;
  logic [3:0]    r_be, w_be;
  logic [31:0]   r_wdata, w_wdata;
  logic [2:0]    r_f3, w_f3;
  logic [1:0]    r_off, w_off;
  logic          r_done, w_done;
  logic          r_mis, w_mis;
  logic          r_berr, w_berr;
  logic [31:0]   r_rdata, w_rdata;
  logic [CW-1:0] r_cnt, w_cnt;

  logic          w_is_b, w_is_h, w_is_w;
  logic          w_bad;
  logic [3:0]    w_be_in;
  logic [31:0]   w_wd_in;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ext;
  logic          w_tmo;

  assign w_is_b = funct3_i[1:0] == 2'b00;
  assign w_is_h = funct3_i[1:0] == 2'b01;
  assign w_is_w = funct3_i[1:0] == 2'b10;

  // Illegal encoding for the direction, or a misaligned H/W access
  assign w_bad =
    (we_i ? (funct3_i[2] | (funct3_i[1:0] == 2'b11))
          : ((funct3_i[1:0] == 2'b11) | (funct3_i == 3'b110)))
    | (w_is_h & addr_i[0])
    | (w_is_w & (addr_i[1:0] != 2'b00));

  // Lane steering of the incoming request
  always_comb begin
    w_be_in = 4'b1111;
    w_wd_in = wdata_i;
    unique case (1'b1)
      w_is_b: begin
        w_be_in = 4'b0001 << addr_i[1:0];
        w_wd_in = {4{wdata_i[7:0]}};
      end
      w_is_h: begin
        w_be_in = addr_i[1] ? 4'b1100 : 4'b0011;
        w_wd_in = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane extraction and extension of returned load data
  always_comb begin
    w_byte = mem_rdata_i[{r_off, 3'b000} +: 8];
    w_half = r_off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    w_ext  = mem_rdata_i;
    unique case (1'b1)
      r_f3[1:0] == 2'b00:
        w_ext = {{24{~r_f3[2] & w_byte[7]}}, w_byte};
      r_f3[1:0] == 2'b01:
        w_ext = {{16{~r_f3[2] & w_half[15]}}, w_half};
      default: ;
    endcase
  end

  assign w_tmo = (MAX_WAIT != 0) && (r_cnt == CW'(MAX_WAIT - 1));

  // Next-state and next-output logic
  always_comb begin
    w_next  = r_state;
    w_valid = r_valid;
    w_we    = r_we;
    w_addr  = r_addr;
    w_be    = r_be;
    w_wdata = r_wdata;
    w_f3    = r_f3;
    w_off   = r_off;
    w_done  = 1'b0;
    w_mis   = 1'b0;
    w_berr  = 1'b0;
    w_rdata = r_rdata;
    w_cnt   = r_cnt + 1'b1;
    unique case (r_state)
      S_IDLE: begin
        if (req_i) begin
          if (w_bad) begin
            w_next = S_DONE;
            w_done = 1'b1;
            w_mis  = 1'b1;
          end else begin
            w_next  = S_REQ;
            w_valid = 1'b1;
            w_we    = we_i;
            w_addr  = {addr_i[31:2], 2'b00};
            w_be    = w_be_in;
            w_wdata = w_wd_in;
            w_f3    = funct3_i;
            w_off   = addr_i[1:0];
            w_cnt   = '0;
          end
        end
      end
      S_REQ: begin
        if (mem_ready_i) begin
          w_valid = 1'b0;
          w_cnt   = '0;
          if (r_we) begin
            w_next = S_DONE;
            w_done = 1'b1;
          end else begin
            w_next = S_WAIT_R;
          end
        end else if (w_tmo) begin
          w_valid = 1'b0;
          w_next  = S_DONE;
          w_done  = 1'b1;
          w_berr  = 1'b1;
        end
      end
      S_WAIT_R: begin
        if (mem_rvalid_i) begin
          w_rdata = w_ext;
          w_next  = S_DONE;
          w_done  = 1'b1;
        end else if (w_tmo) begin
          w_next = S_DONE;
          w_done = 1'b1;
          w_berr = 1'b1;
        end
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_f3    <= '0;
      r_off   <= '0;
      r_done  <= 1'b0;
      r_mis   <= 1'b0;
      r_berr  <= 1'b0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_valid <= w_valid;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_be    <= w_be;
      r_wdata <= w_wdata;
      r_f3    <= w_f3;
      r_off   <= w_off;
      r_done  <= w_done;
      r_mis   <= w_mis;
      r_berr  <= w_berr;
      r_rdata <= w_rdata;
      r_cnt   <= w_cnt;
    end
  end

  assign stall_o     = req_i & ~r_done;
  assign done_o      = r_done;
  assign rdata_o     = r_rdata;
  assign misalign_o  = r_mis;
  assign bus_err_o   = r_berr;
  assign mem_valid_o = r_valid;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_be_o    = r_be;
  assign mem_wdata_o = r_wdata;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory access stage directly downstream of the ALU in the RV32I core.
- Takes the ALU result (FU) as the effective address plus rs2 store data.
- Runs a valid/ready bus transaction with byte-lane steering, then returns sign- or zero-extended load data.
- Stalls the core until the access completes, is rejected for misalignment, or times out.

Parameters:
- MAX_WAIT, 255: cycles allowed in REQ or WAIT_R before bus error; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous active-low reset
- req_i  in  1  core requests a load/store; held high until done_o
- we_i  in  1  1 = store, 0 = load
- funct3_i  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- addr_i  in  32  effective address from ALU FU
- wdata_i  in  32  store data (rs2)
- stall_o  out  1  combinational: req_i & ~done_o
- done_o  out  1  one-cycle completion pulse
- rdata_o  out  32  extended load result
- misalign_o  out  1  valid with done_o: misaligned address or illegal funct3
- bus_err_o  out  1  valid with done_o: timeout
- mem_valid_o  out  1  bus request valid
- mem_ready_i  in  1  bus accepts request
- mem_we_o  out  1  bus write
- mem_addr_o  out  32  {addr[31:2],2'b00}
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  lane-replicated store data
- mem_rdata_i  in  32  read word
- mem_rvalid_i  in  1  read data valid

Behaviour:
- Reset (async, reset=0): state IDLE; timeout counter 0.
- Reset forces all mem_* outputs, done_o, misalign_o, bus_err_o and rdata_o to 0.
- Reset mid-transaction drops mem_valid_o immediately, with no completion pulse.
- States: IDLE, REQ, WAIT_R, DONE. All outputs except stall_o are registered.
- IDLE, req_i=1, checks:
  - funct3 illegal for direction (loads: 011/110/111; stores: anything but 000/001/010) -> DONE, misalign_o=1, no bus access.
  - H with addr[0]=1, or W with addr[1:0]!=0 -> DONE, misalign_o=1, no bus access.
  - Otherwise latch we, funct3, addr[1:0], be, wdata; assert mem_valid_o; -> REQ.
- REQ: mem_valid_o, address, be, wdata and we are held stable until mem_ready_i.
  - On valid&ready, store: deassert valid -> DONE.
  - On valid&ready, load: deassert valid -> WAIT_R.
- WAIT_R:
  - mem_rvalid_i is sampled only from the cycle after acceptance.
  - On rvalid, the extracted lane is extended into rdata_o -> DONE.
- Timeout: counter clears on entering REQ/WAIT_R and increments each cycle there.
  - When MAX_WAIT!=0 and counter==MAX_WAIT-1 without progress: drop valid -> DONE, bus_err_o=1, rdata_o unchanged.
- DONE: done_o=1 for exactly one cycle -> IDLE. misalign_o and bus_err_o are 0 outside done_o.
- req_i in IDLE is always a new request; the core changes it only after done_o.
- Byte lanes, off = addr[1:0]:
  - B: be=0001<<off, wdata={4{wdata_i[7:0]}}.
  - H: be=off[1]?1100:0011, wdata={2{wdata_i[15:0]}}.
  - W: be=1111, wdata=wdata_i.
  - Loads use the same be.
- Load extract: B/BU take byte off; H/HU take halfword off[1]. B/H sign-extend; BU/HU zero-extend.
- rdata_o holds its value until the next successful load.
- Latency, zero wait states: store done_o 2 cycles after req_i sampled; load with rvalid the cycle after accept, done_o 3 cycles after.

Test Plan:
- Store B, addr=0x1003, wdata=0x000000A5, ready=1 -> mem_addr=0x1000, be=1000, wdata=0xA5A5A5A5; done_o 2 cycles after req; no flags.
- Load B addr=0x2001 and load BU addr=0x2001, rdata_i=0x1234F678, rvalid next cycle -> rdata_o=0xFFFFFFF6, then 0x000000F6; done_o 3 cycles after req.
- Load HU addr=0x2002, rdata_i=0x8001_7FFF -> rdata_o=0x00008001. Load H at the same address -> 0xFFFF8001.
- Load W addr=0x3002, or store with funct3=100 -> mem_valid_o never asserts; done_o with misalign_o=1 one cycle later.
- mem_ready_i held low for 3 cycles then high -> mem_valid_o, addr, be, wdata stable across the wait; done_o follows acceptance; stall_o high throughout.
- MAX_WAIT=4, ready never asserts -> valid drops after 4 REQ cycles, done_o with bus_err_o=1.
- Reset asserted during WAIT_R -> IDLE, all outputs 0 immediately, no done_o.
